// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA transfer controller: register file, address/word counters and IDLE/WAIT/ACK/DONE handshake FSM.
// Optional feature: define DMA_AUTO_RELOAD_EN to enable block auto-reload when ctrl[1]=1.
module dma_xfer_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              start,
    input  logic              abort,
    input  logic              dreq,
    output logic              dack,
    output logic [ADDR_W-1:0] addr_out,
    output logic [CNT_W-1:0]  words_left,
    output logic              busy,
    output logic              tc,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef DMA_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr_base;
    logic [CNT_W-1:0]  count_init;
    logic [1:0]        ctrl;
    logic              reload_en;
    logic              cfg_open;

    // ctrl[1] is kept in every build; it only has an effect when reload is compiled in.
    assign reload_en = AUTO_RELOAD & ctrl[1];
    assign cfg_open  = (state == S_IDLE) || (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, as real flops do.
    always_ff @(posedge clk) begin
        if (res) begin
            state      <= S_IDLE;
            addr_base  <= '0;
            count_init <= '0;
            ctrl       <= '0;
            addr_out   <= '0;
            words_left <= '0;
            dack       <= 1'b0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (cfg_wr && cfg_open) begin
                case (cfg_sel)
                    2'd0:    addr_base  <= cfg_data;
                    2'd1:    count_init <= cfg_data[CNT_W-1:0];
                    2'd2:    ctrl       <= cfg_data[1:0];
                    default: ;
                endcase
            end

            if (abort) begin
                // Counters deliberately hold their values so software can see how far the block got.
                state <= S_IDLE;
                dack  <= 1'b0;
                tc    <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            addr_out   <= addr_base;
                            words_left <= count_init;
                            dack       <= 1'b0;
                            tc         <= 1'b0;
                            if (count_init == '0) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                                busy  <= 1'b1;
                                done  <= 1'b0;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (dreq) begin
                            state <= S_ACK;
                            dack  <= 1'b1;
                            tc    <= (words_left == CNT_ONE);
                        end
                    end
                    S_ACK: begin
                        dack <= 1'b0;
                        tc   <= 1'b0;
                        if (words_left == CNT_ONE && reload_en) begin
                            addr_out   <= addr_base;
                            words_left <= count_init;
                            state      <= S_WAIT;
                        end else begin
                            addr_out   <= ctrl[0] ? addr_out + ADDR_ONE : addr_out - ADDR_ONE;
                            words_left <= words_left - CNT_ONE;
                            if (words_left == CNT_ONE) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: directed scenarios plus randomized blocks checked against
// an arithmetic model of the expected address/tc sequence.
module tb_dma_xfer_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [7:0] cfg_data = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dreq = 1'b0;
    logic       dack;
    logic [7:0] addr_out;
    logic [7:0] words_left;
    logic       busy;
    logic       tc;
    logic       done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    dma_xfer_ctrl #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .res        (res),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .start      (start),
        .abort      (abort),
        .dreq       (dreq),
        .dack       (dack),
        .addr_out   (addr_out),
        .words_left (words_left),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // Runs one block; the model: k-th dack carries base +/- (k mod cnt), tc on the last word of each block.
    task automatic xfer(input logic [7:0] base, input logic [7:0] cnt, input logic [1:0] c,
                        input int dreq_pct, input bit reload);
        int         n;
        int         k;
        int         last;
        int         budget;
        int         off;
        logic [7:0] exp_a;
        cfg(2'd0, base);
        cfg(2'd1, cnt);
        cfg(2'd2, {6'b0, c});
        start = 1'b1;
        tick();
        start = 1'b0;
        if (cnt == 8'd0) begin
            check("zc_done", done, 1);
            check("zc_busy", busy, 0);
            dreq = 1'b1;
            repeat (4) begin
                tick();
                check("zc_no_dack_tc", {dack, tc}, 0);
            end
            dreq = 1'b0;
            check("zc_still_done", done, 1);
            return;
        end
        check("st_busy", busy, 1);
        check("st_words", words_left, cnt);
        check("st_addr", addr_out, base);
        n      = reload ? 3 * int'(cnt) : int'(cnt);
        k      = 0;
        last   = -10;
        budget = 0;
        while (k < n && budget < 2000) begin
            dreq = ($urandom_range(99) < dreq_pct);
            tick();
            budget++;
            if (reload) check("rl_done_low", done, 0);
            if (tc && !dack) check("tc_without_dack", tc, 0);
            if (dack) begin
                off   = k % int'(cnt);
                exp_a = c[0] ? base + 8'(off) : base - 8'(off);
                check("dack_addr", addr_out, exp_a);
                check("dack_tc", tc, (off == int'(cnt) - 1));
                check("dack_gap", (cyc - last) >= 2, 1);
                check("dack_busy_done", {busy, done}, 2'b10);
                last = cyc;
                k++;
            end
        end
        check("dack_count", k, n);
        dreq = 1'b0;
        if (reload) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("rl_abort", {busy, done, dack}, 0);
        end else begin
            tick();
            exp_a = c[0] ? base + cnt : base - cnt;
            check("end_flags", {done, busy, dack, tc}, 4'b1000);
            check("end_words", words_left, 0);
            check("end_addr", addr_out, exp_a);
        end
    endtask

    int         k2;
    int         bud;
    logic [7:0] r_base;
    logic [7:0] r_cnt;
    logic [1:0] r_ctrl;

    initial begin
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
        check("rst_flags", {dack, busy, tc, done}, 0);
        check("rst_addr", addr_out, 0);
        check("rst_words", words_left, 0);

        // Zero count from IDLE, then basic up and down-with-wrap blocks.
        xfer(8'h10, 8'd0, 2'b01, 100, 1'b0);
        xfer(8'h10, 8'd3, 2'b01, 100, 1'b0);
        xfer(8'h01, 8'd3, 2'b00, 100, 1'b0);

        // Abort after the 2nd dack; a write to addr_base while busy must be dropped.
        cfg(2'd0, 8'h20);
        cfg(2'd1, 8'd5);
        cfg(2'd2, 8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        dreq  = 1'b1;
        k2    = 0;
        bud   = 0;
        while (k2 < 2 && bud < 100) begin
            tick();
            bud++;
            if (dack) k2++;
        end
        check("ab_dacks", k2, 2);
        cfg(2'd0, 8'h77);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        dreq  = 1'b0;
        check("ab_words", words_left, 3);
        check("ab_addr", addr_out, 8'h22);
        check("ab_flags", {busy, dack, done, tc}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_base_kept", addr_out, 8'h20);
        check("ab_count_kept", words_left, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset while in ACK clears everything, including the config registers.
        cfg(2'd0, 8'h44);
        cfg(2'd1, 8'd4);
        cfg(2'd2, 8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        dreq  = 1'b1;
        bud   = 0;
        while (!dack && bud < 100) begin
            tick();
            bud++;
        end
        check("rm_in_ack", dack, 1);
        res = 1'b1;
        tick();
        res  = 1'b0;
        dreq = 1'b0;
        check("rm_flags", {dack, busy, tc, done}, 0);
        check("rm_addr", addr_out, 0);
        check("rm_words", words_left, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rm_cfg_cleared", {done, addr_out, words_left}, 17'h10000);

`ifdef DMA_AUTO_RELOAD_EN
        xfer(8'h10, 8'd2, 2'b11, 100, 1'b1);
`else
        xfer(8'h10, 8'd2, 2'b11, 100, 1'b0);
`endif

        repeat (10) begin
            r_base = 8'($urandom);
            r_cnt  = 8'($urandom_range(6));
            r_ctrl = 2'($urandom_range(3));
`ifdef DMA_AUTO_RELOAD_EN
            r_ctrl[1] = 1'b0;
`endif
            xfer(r_base, r_cnt, r_ctrl, int'($urandom_range(40, 100)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
